// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared constants and types for the IEEE-754 unpacker.
//               Holds the exponent biases, exponent-field all-ones values,
//               the field widths, the default unbiased exponent width, the
//               significand width, and the sequencer state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package fpu_pkg;

    // Field widths of the two supported formats
    localparam int EXP_W_D  = 11;
    localparam int FRAC_W_D = 52;
    localparam int EXP_W_S  = 8;
    localparam int FRAC_W_S = 23;

    // Significand including the hidden bit (double width; single is left-aligned)
    localparam int SIG_W = 53;

    // Default width of the signed unbiased exponent output
    localparam int EOUT_W_DEFAULT = 13;

    // Exponent biases
    localparam int BIAS_D = 1023;
    localparam int BIAS_S = 127;

    // All-ones exponent field values, expressed in the 11-bit raw field space
    localparam logic [EXP_W_D-1:0] EXP_ONES_D = 11'd2047;
    localparam logic [EXP_W_D-1:0] EXP_ONES_S = 11'd255;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
// Module      : fp_classify
// Description : Combinational field extraction and classification of a
//               packed IEEE-754 operand (double or single).
//
// Ports
//   op_i      [63:0] packed operand; single uses op_i[31:0]
//   db_i             1 = double, 0 = single
//   sign_o           sign bit
//   exp_o     [10:0] raw exponent field, zero-extended for single
//   frac_o    [51:0] raw fraction, left-aligned for single (low 29 bits 0)
//   zero_o           exponent 0, fraction 0
//   inf_o            exponent all-ones, fraction 0
//   nan_o            exponent all-ones, fraction non-zero
//   snan_o           NaN with fraction MSB clear (signalling)
//   denorm_o         exponent 0, fraction non-zero
// Revision    : 1.0  initial release
// ============================================================================
module fp_classify
    import fpu_pkg::*;
(
    input  logic [63:0]          op_i,
    input  logic                 db_i,
    output logic                 sign_o,
    output logic [EXP_W_D-1:0]   exp_o,
    output logic [FRAC_W_D-1:0]  frac_o,
    output logic                 zero_o,
    output logic                 inf_o,
    output logic                 nan_o,
    output logic                 snan_o,
    output logic                 denorm_o
);

    logic w_exp_zero;
    logic w_exp_ones;
    logic w_frac_zero;

    // Field extraction. Single-precision fields are moved into the double
    // field positions so that everything downstream is format-agnostic:
    // the fraction is left-aligned, so its MSB is always frac_o[51].
    always_comb begin
        sign_o     = 1'b0;
        exp_o      = '0;
        frac_o     = '0;
        w_exp_ones = 1'b0;
        if (db_i) begin
            sign_o     = op_i[63];
            exp_o      = op_i[62:52];
            frac_o     = op_i[51:0];
            w_exp_ones = (op_i[62:52] == EXP_ONES_D);
        end else begin
            sign_o     = op_i[31];
            exp_o      = {3'b000, op_i[30:23]};
            frac_o     = {op_i[22:0], {(FRAC_W_D-FRAC_W_S){1'b0}}};
            w_exp_ones = ({3'b000, op_i[30:23]} == EXP_ONES_S);
        end
    end

    assign w_exp_zero  = (exp_o == '0);
    assign w_frac_zero = (frac_o == '0);

    assign zero_o   = w_exp_zero &  w_frac_zero;
    assign denorm_o = w_exp_zero & ~w_frac_zero;
    assign inf_o    = w_exp_ones &  w_frac_zero;
    assign nan_o    = w_exp_ones & ~w_frac_zero;
    // Quiet bit is the fraction MSB; a NaN with it clear is signalling
    assign snan_o   = nan_o & ~frac_o[FRAC_W_D-1];

endmodule : fp_classify
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fp_unpack
// Description : Unpacks an IEEE-754 double or single operand into sign,
//               signed unbiased exponent, 53-bit significand with explicit
//               hidden bit, and class flags. Denormals are normalised by a
//               one-bit-per-cycle shift so the result always has f[52]=1
//               unless the operand is zero.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset
//   in_valid / in_ready  operand handshake (ready only while idle)
//   op       [63:0]      packed operand; single uses op[31:0]
//   db                   1 = double, 0 = single
//   out_valid/out_ready  result handshake; result held until taken
//   s                    sign
//   e   [EOUT_W-1:0]     two's-complement unbiased exponent
//   f   [52:0]           significand, hidden bit at f[52]
//   zero, inf, nan, snan, denorm   class flags
// Revision    : 1.0  initial release
// ============================================================================
module fp_unpack
    import fpu_pkg::*;
#(
    parameter int EOUT_W = EOUT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              op,
    input  logic                     db,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     s,
    output logic signed [EOUT_W-1:0] e,
    output logic [SIG_W-1:0]         f,
    output logic                     zero,
    output logic                     inf,
    output logic                     nan,
    output logic                     snan,
    output logic                     denorm
);

    localparam logic signed [EOUT_W-1:0] E_ONE = EOUT_W'(1);

    // ------------------------------------------------------------------
    // Classification of the offered operand
    // ------------------------------------------------------------------
    logic                 w_sign;
    logic [EXP_W_D-1:0]   w_exp_raw;
    logic [FRAC_W_D-1:0]  w_frac;
    logic                 w_zero;
    logic                 w_inf;
    logic                 w_nan;
    logic                 w_snan;
    logic                 w_denorm;

    fp_classify u_classify (
        .op_i     (op),
        .db_i     (db),
        .sign_o   (w_sign),
        .exp_o    (w_exp_raw),
        .frac_o   (w_frac),
        .zero_o   (w_zero),
        .inf_o    (w_inf),
        .nan_o    (w_nan),
        .snan_o   (w_snan),
        .denorm_o (w_denorm)
    );

    // ------------------------------------------------------------------
    // Values loaded on acceptance
    // ------------------------------------------------------------------
    logic signed [EOUT_W-1:0] w_bias;
    logic signed [EOUT_W-1:0] w_exp_ext;
    logic signed [EOUT_W-1:0] e_d;
    logic [SIG_W-1:0]         f_d;

    assign w_bias    = db ? EOUT_W'(BIAS_D) : EOUT_W'(BIAS_S);
    assign w_exp_ext = {{(EOUT_W-EXP_W_D){1'b0}}, w_exp_raw};

    // Zero reports exponent 0. A denormal starts at the minimum normal
    // exponent (1 - bias) and is then walked down by the NORM shifts. For
    // normal and all-ones operands plain exp - bias applies (all-ones
    // yields bias+1).
    always_comb begin
        e_d = w_exp_ext - w_bias;
        if (w_zero) begin
            e_d = '0;
        end else if (w_denorm) begin
            e_d = E_ONE - w_bias;
        end
    end

    // Hidden bit is set whenever the exponent field is non-zero
    assign f_d = {~(w_zero | w_denorm), w_frac};

    // ------------------------------------------------------------------
    // Sequencer with registered outputs
    // ------------------------------------------------------------------
    state_t                   state_q;
    logic                     out_valid_q;
    logic                     s_q;
    logic signed [EOUT_W-1:0] e_q;
    logic [SIG_W-1:0]         f_q;
    logic                     zero_q;
    logic                     inf_q;
    logic                     nan_q;
    logic                     snan_q;
    logic                     denorm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            s_q         <= 1'b0;
            e_q         <= '0;
            f_q         <= '0;
            zero_q      <= 1'b0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            snan_q      <= 1'b0;
            denorm_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // in_ready is asserted throughout IDLE outside reset
                    if (in_valid) begin
                        s_q      <= w_sign;
                        e_q      <= e_d;
                        f_q      <= f_d;
                        zero_q   <= w_zero;
                        inf_q    <= w_inf;
                        nan_q    <= w_nan;
                        snan_q   <= w_snan;
                        denorm_q <= w_denorm;
                        if (w_denorm) begin
                            state_q <= ST_NORM;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end

                ST_NORM: begin
                    f_q <= f_q << 1;
                    e_q <= e_q - E_ONE;
                    // Bit 51 is about to be shifted into the hidden position
                    if (f_q[SIG_W-2]) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end

                ST_DONE: begin
                    // Result registers are left untouched; only the
                    // handshake releases the block
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Gated by rst so that ready stays low while reset is held, and rises
    // as soon as it is released.
    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign e         = e_q;
    assign f         = f_q;
    assign zero      = zero_q;
    assign inf       = inf_q;
    assign nan       = nan_q;
    assign snan      = snan_q;
    assign denorm    = denorm_q;

endmodule : fp_unpack
`default_nettype wire

// File: tb/tb_fp_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_unpack
// Description : Directed self-checking bench for fp_unpack. Expected values
//               are hand-computed IEEE-754 field decodes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fp_unpack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op;
    logic        db;
    logic        out_valid;
    logic        out_ready;
    logic        s;
    logic [12:0] e_w;
    logic [52:0] f;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        snan;
    logic        denorm;

    int checks = 0;
    int errors = 0;

    fp_unpack #(.EOUT_W(13)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .db        (db),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .e         (e_w),
        .f         (f),
        .zero      (zero),
        .inf       (inf),
        .nan       (nan),
        .snan      (snan),
        .denorm    (denorm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] e13(input int v);
        logic [31:0] t;
        t = v;
        return t[12:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand; returns just after the accepting edge
    task automatic offer(input logic [63:0] v, input logic d);
        op       = v;
        db       = d;
        in_valid = 1'b1;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        op       = 64'h0;
    endtask

    // flags ordering: {zero, inf, nan, snan, denorm}
    task automatic expect_result(input string tag, input logic es, input int ee,
                                 input logic [52:0] ef, input logic [4:0] efl);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_s"},     64'(s), 64'(es));
        check({tag, "_e"},     64'(e_w), 64'(e13(ee)));
        check({tag, "_f"},     64'(f), 64'(ef));
        check({tag, "_flags"}, 64'({zero, inf, nan, snan, denorm}), 64'(efl));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_after_hs"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_after_hs"}, 64'(in_ready), 64'd1);
    endtask

    // Counts edges after the accept edge until out_valid rises (bounded)
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 64'h0;
        db        = 1'b0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_s",         64'(s),         64'd0);
        check("rst_e",         64'(e_w),       64'd0);
        check("rst_f",         64'(f),         64'd0);
        check("rst_flags",     64'({zero, inf, nan, snan, denorm}), 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(in_ready), 64'd1);
        tick();

        // ---------------- double 1.0, one-cycle latency ----------------
        offer(64'h3FF0000000000000, 1'b1);
        expect_result("one_d", 1'b0, 0, {1'b1, 52'b0}, 5'b00000);

        // Hold for 5 cycles with out_ready low
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_ready", 64'(in_ready),  64'd0);
            check("hold_e",     64'(e_w),       64'd0);
            check("hold_f",     64'(f),         64'({1'b1, 52'b0}));
        end
        handshake("one_d");

        // ---------------- smallest double denormal, k = 52 ----------------
        offer(64'h0000000000000001, 1'b1);
        check("dmin_not_valid_yet", 64'(out_valid), 64'd0);
        wait_valid(n);
        check("dmin_latency", 64'(n), 64'd52);
        expect_result("dmin", 1'b0, -1074, {1'b1, 52'b0}, 5'b00001);
        handshake("dmin");

        // ---------------- single -0.0 ----------------
        offer(64'h0000000080000000, 1'b0);
        expect_result("nzero_s", 1'b1, 0, 53'b0, 5'b10000);
        handshake("nzero_s");

        // ---------------- single signalling NaN ----------------
        offer(64'h000000007FA00000, 1'b0);
        expect_result("snan_s", 1'b0, 128, {3'b101, 50'b0}, 5'b00110);
        handshake("snan_s");

        // ---------------- single pi, garbage in upper word ----------------
        offer(64'hDEADBEEF40490FDB, 1'b0);
        expect_result("pi_s", 1'b0, 1, {24'hC90FDB, 29'b0}, 5'b00000);
        handshake("pi_s");

        // ---------------- double -infinity ----------------
        offer(64'hFFF0000000000000, 1'b1);
        expect_result("ninf_d", 1'b1, 1024, {1'b1, 52'b0}, 5'b01000);
        handshake("ninf_d");

        // ---------------- double quiet NaN ----------------
        offer(64'h7FF8000000000000, 1'b1);
        expect_result("qnan_d", 1'b0, 1024, {2'b11, 51'b0}, 5'b00100);
        handshake("qnan_d");

        // ---------------- smallest single denormal, k = 23 ----------------
        offer(64'h0000000000000001, 1'b0);
        wait_valid(n);
        check("smin_latency", 64'(n), 64'd23);
        expect_result("smin", 1'b0, -149, {1'b1, 52'b0}, 5'b00001);
        handshake("smin");

        // ---------------- largest-fraction single denormal, k = 1 ----------------
        offer(64'h0000000000400000, 1'b0);
        wait_valid(n);
        check("sden1_latency", 64'(n), 64'd1);
        expect_result("sden1", 1'b0, -127, {1'b1, 52'b0}, 5'b00001);
        handshake("sden1");

        // ---------------- reset mid-NORM ----------------
        offer(64'h0000000000000001, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check("midnorm_not_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;
        #1;
        check("midrst_valid",  64'(out_valid), 64'd0);
        check("midrst_ready",  64'(in_ready),  64'd0);
        check("midrst_f",      64'(f),         64'd0);
        check("midrst_e",      64'(e_w),       64'd0);
        check("midrst_flags",  64'({zero, inf, nan, snan, denorm}), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_ready_release", 64'(in_ready), 64'd1);
        tick();
        check("midrst_still_idle", 64'(out_valid), 64'd0);

        // Recovery after reset
        offer(64'h3FF0000000000000, 1'b1);
        expect_result("recover", 1'b0, 0, {1'b1, 52'b0}, 5'b00000);
        handshake("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fp_unpack
`default_nettype wire
